// File: rtl/scan_pkg.sv
// Shared definitions for the round-robin index scanner: channel count, index width
// and FSM state encoding.
package scan_pkg;

  localparam int N_CH  = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requesting channel after 'last', wrapping mod N_CH.
module rr_priority_pick
  import scan_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] pick,
  output logic             found
);

  logic [IDX_W-1:0]  start;
  logic [IDX_W-1:0]  off;
  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;

  always_comb begin
    start = last + IDX_W'(1);
    // Doubling the vector turns the right rotation into a plain shift.
    dbl   = {req, req} >> start;
    rot   = dbl[N_CH-1:0];
    found = |req;
    off   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot[k]) off = IDX_W'(k);
    end
    pick = start + off;
  end

endmodule

// File: rtl/rr_index_scanner.sv
// Round-robin channel scanner: selects requesting channels in rotation, holds each for
// dwell+1 cycles and pulses wrap when a rotation completes.
module rr_index_scanner
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_CH-1:0]    req,
  input  logic [DWELL_W-1:0] dwell,
  output logic [IDX_W-1:0]   idx,
  output logic               idx_valid,
  output logic               wrap
);

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   pick;
  logic               found;

  rr_priority_pick u_pick (
    .req   (req),
    .last  (last),
    .pick  (pick),
    .found (found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      idx_valid <= 1'b0;
      wrap      <= 1'b0;
      cnt       <= '0;
      // Starting from the top channel makes the first search begin at channel 0.
      last      <= IDX_W'(N_CH - 1);
    end else begin
      case (state)
        S_IDLE: begin
          idx_valid <= 1'b0;
          wrap      <= 1'b0;
          if (en && found) state <= S_SEARCH;
        end
        S_SEARCH: begin
          if (!en || !found) begin
            state     <= S_IDLE;
            idx_valid <= 1'b0;
            wrap      <= 1'b0;
          end else begin
            state     <= S_HOLD;
            idx       <= pick;
            last      <= pick;
            idx_valid <= 1'b1;
            cnt       <= dwell;
            wrap      <= (pick <= last);
          end
        end
        S_HOLD: begin
          wrap <= 1'b0;
          if (cnt != '0) cnt <= cnt - DWELL_W'(1);
          // Disable beats a dropped requester, which beats normal slot expiry.
          if (!en) begin
            state     <= S_IDLE;
            idx_valid <= 1'b0;
          end else if (!req[idx]) begin
            state     <= S_SEARCH;
            idx_valid <= 1'b0;
          end else if (cnt == '0) begin
            state     <= S_SEARCH;
            idx_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          idx_valid <= 1'b0;
          wrap      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_index_scanner.sv
// Bench for rr_index_scanner: directed scenarios plus random traffic, checked every
// cycle against a slot-level reference model.
module tb_rr_index_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] dwell = 8'h00;
  logic [2:0] idx;
  logic       idx_valid;
  logic       wrap;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: activity is "idle", "looking" or "serving" a channel.
  int m_act;
  int m_idx, m_last, m_left;
  bit m_valid, m_wrap;

  rr_index_scanner #(.DWELL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .dwell     (dwell),
    .idx       (idx),
    .idx_valid (idx_valid),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_idx = 0; m_last = 7; m_left = 0; m_valid = 0; m_wrap = 0;
  endtask

  function automatic int next_channel(input int from, input logic [7:0] r);
    for (int k = 1; k <= 8; k++) begin
      if (r[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int p;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_act == 0) begin
      m_valid = 0; m_wrap = 0;
      if (en && req != 0) m_act = 1;
    end else if (m_act == 1) begin
      p = next_channel(m_last, req);
      if (!en || p < 0) begin
        m_act = 0; m_valid = 0; m_wrap = 0;
      end else begin
        m_wrap = (p <= m_last);
        m_idx = p; m_last = p; m_valid = 1; m_left = dwell; m_act = 2;
      end
    end else begin
      m_wrap = 0;
      if (!en) begin
        m_act = 0; m_valid = 0;
      end else if (!req[m_idx] || m_left == 0) begin
        m_act = 1; m_valid = 0;
      end else begin
        m_left--;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".valid"}, 32'(idx_valid), 32'(m_valid));
    chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    chk({tag, ".idx"}, 32'(idx), 32'(m_idx));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic wait_sel(input string tag, input int target, input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      step(tag);
      if (idx_valid && (target < 0 || int'(idx) == target)) hit = 1;
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s_timeout observed=no_selection expected=channel_%0d", tag, target);
    end
  endtask

  initial begin
    model_reset();
    #12;
    rst = 1'b0;
    #1;
    chk("reset.idx", 32'(idx), 0);
    chk("reset.valid", 32'(idx_valid), 0);
    chk("reset.wrap", 32'(wrap), 0);

    // 1: enabled with no requests stays idle
    en = 1'b1; req = 8'h00;
    repeat (20) step("t1_noreq");

    // 2: all channels, dwell 2 -> 0..7,0 each held 3 cycles
    req = 8'hFF; dwell = 8'd2;
    repeat (40) step("t2_all");

    // 3: channels 2 and 7 with 1-cycle slots
    rst = 1'b1; #1; model_reset(); #2; rst = 1'b0;
    req = 8'b1000_0100; dwell = 8'd0;
    wait_sel("t3_first", 2, 10);
    chk("t3_wrap_on_2", 32'(wrap), 1);
    repeat (12) step("t3_alt");

    // 4: single requester dropped mid-slot
    en = 1'b0; repeat (3) step("t4_drain");
    en = 1'b1; req = 8'h10; dwell = 8'd5;
    wait_sel("t4_sel", 4, 10);
    step("t4_hold2");
    step("t4_hold3");
    req = 8'h00;
    step("t4_drop1");
    step("t4_drop2");
    chk("t4_valid_after_drop", 32'(idx_valid), 0);
    repeat (3) step("t4_idle");

    // 5: asynchronous reset in the middle of a slot on channel 5
    req = 8'hFF; dwell = 8'd3;
    wait_sel("t5_sel", 5, 60);
    step("t5_hold");
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t5_async_idx", 32'(idx), 0);
    chk("t5_async_valid", 32'(idx_valid), 0);
    step("t5_in_rst");
    #2 rst = 1'b0;
    wait_sel("t5_restart", -1, 10);
    chk("t5_first_after_rst", 32'(idx), 0);

    // 6: disable during a slot on channel 3, then resume at 4
    wait_sel("t6_sel", 3, 60);
    en = 1'b0;
    step("t6_off");
    chk("t6_off_valid", 32'(idx_valid), 0);
    chk("t6_off_idx", 32'(idx), 3);
    repeat (2) step("t6_idle");
    en = 1'b1;
    wait_sel("t6_resume", -1, 10);
    chk("t6_next_is_4", 32'(idx), 4);

    // Maximum dwell on a single channel: 256-cycle slot
    req = 8'h01; dwell = 8'd255;
    repeat (270) step("max_dwell");

    // Random traffic, including mid-slot request and dwell changes
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      if ($urandom_range(0, 5) == 0) dwell = 8'($urandom_range(0, 6));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
